// File: rtl/egg_timer_pkg.sv
// Shared egg-timer UI definitions: FSM encoding for the button
// autorepeat block and default tick constants reused by other UI blocks.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } btn_state_e;

  localparam int DEF_DELAY_TICKS  = 3;
  localparam int DEF_REPEAT_TICKS = 1;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_ACCEL_AFTER  = 4;
  localparam int DEF_FAST_TICKS   = 1;

endpackage

// File: rtl/button_autorepeat_if.sv
// Control/strobe bundle between the divider/debouncer side and the
// button autorepeat block.
interface button_autorepeat_if;
  logic tick_en;
  logic btn_level;
  logic enable;
  logic step_pulse;
  logic held;
  logic fast;

  modport master (
    output tick_en,
    output btn_level,
    output enable,
    input  step_pulse,
    input  held,
    input  fast
  );

  modport slave (
    input  tick_en,
    input  btn_level,
    input  enable,
    output step_pulse,
    output held,
    output fast
  );
endinterface

// File: rtl/sync_2ff.sv
// Parameterizable-width two-flop synchronizer with async active-high
// reset, shared by all button inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/button_autorepeat.sv
// Button press -> increment strobes with hold delay and repeat cadence.
// Optional accelerated cadence when BTN_ACCEL_EN is defined.
module button_autorepeat
  import egg_timer_pkg::*;
#(
  parameter int DELAY_TICKS  = DEF_DELAY_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int ACCEL_AFTER  = DEF_ACCEL_AFTER,
  parameter int FAST_TICKS   = DEF_FAST_TICKS
) (
  input logic          clk,
  input logic          reset,
  button_autorepeat_if.slave bus
);
  localparam logic [CNT_W-1:0] LP_DLY = CNT_W'(DELAY_TICKS);
  localparam logic [CNT_W-1:0] LP_REP = CNT_W'(REPEAT_TICKS);

  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step_pulse;
  logic             r_held;
  logic             w_btn_s;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_period;

  sync_2ff #(.W(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.btn_level),
    .o_q   (w_btn_s)
  );

  assign w_cnt_inc = r_cnt + 1'b1;

`ifdef BTN_ACCEL_EN
  localparam logic [CNT_W-1:0] LP_FST = CNT_W'(FAST_TICKS);
  localparam logic [CNT_W-1:0] LP_ACC = CNT_W'(ACCEL_AFTER);

  logic [CNT_W-1:0] r_rep;
  logic             r_fast;
  logic             w_rep_sat;

  assign w_rep_sat = (r_rep == LP_ACC);
  assign w_period  = (r_state == ST_DELAY) ? LP_DLY :
                     w_rep_sat             ? LP_FST : LP_REP;
  assign bus.fast  = r_fast;
`else
  assign w_period  = (r_state == ST_DELAY) ? LP_DLY : LP_REP;
  assign bus.fast  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_step_pulse <= 1'b0;
      r_held       <= 1'b0;
`ifdef BTN_ACCEL_EN
      r_rep        <= '0;
      r_fast       <= 1'b0;
`endif
    end else begin
      r_step_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_btn_s) begin
            if (bus.enable) begin
              r_state      <= ST_DELAY;
              r_step_pulse <= 1'b1;
              r_held       <= 1'b1;
            end else begin
              r_state <= ST_LOCKOUT;
            end
          end
        end
        ST_DELAY, ST_REPEAT: begin
          // release outranks disable, which outranks a terminal count
          if (!w_btn_s || !bus.enable) begin
            r_state <= w_btn_s ? ST_LOCKOUT : ST_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
`ifdef BTN_ACCEL_EN
            r_rep   <= '0;
            r_fast  <= 1'b0;
`endif
          end else if (bus.tick_en) begin
            if (w_cnt_inc == w_period) begin
              r_step_pulse <= 1'b1;
              r_cnt        <= '0;
              r_state      <= ST_REPEAT;
`ifdef BTN_ACCEL_EN
              if (r_state == ST_REPEAT && !w_rep_sat) begin
                r_rep <= r_rep + 1'b1;
                if ((r_rep + 1'b1) == LP_ACC) r_fast <= 1'b1;
              end
`endif
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        ST_LOCKOUT: begin
          r_cnt <= '0;
          if (!w_btn_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.step_pulse = r_step_pulse;
  assign bus.held       = r_held;
endmodule

// File: tb/tb_button_autorepeat.sv
// Randomized self-checking bench for button_autorepeat against a
// behavioural press/hold/repeat model.
module tb_button_autorepeat;
  import egg_timer_pkg::*;

  localparam int D = 3;
  localparam int A = 4;
  localparam int F = 1;
`ifdef BTN_ACCEL_EN
  localparam int R = 4;
  localparam bit ACC = 1'b1;
`else
  localparam int R = 1;
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  button_autorepeat_if u_bus ();

  button_autorepeat #(
    .DELAY_TICKS  (D),
    .REPEAT_TICKS (R),
    .CNT_W        (8),
    .ACCEL_AFTER  (A),
    .FAST_TICKS   (F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_bus)
  );

  always #5 clk = ~clk;

  logic [2:0] obs;
  assign obs = {u_bus.step_pulse, u_bus.held, u_bus.fast};

  bit         hist[$];
  bit         m_act, m_lock, m_first;
  int         m_since, m_nrep;
  logic [2:0] exp_o;
  int         total, bad, edge_n;

  task automatic m_reset();
    hist.delete();
    m_act = 0; m_lock = 0; m_first = 0;
    m_since = 0; m_nrep = 0;
    exp_o = 3'b000;
  endtask

  task automatic m_update(input bit t, input bit e, input bit b);
    bit s, p;
    int need;
    hist.push_back(b);
    s = (hist.size() >= 3) ? hist[0] : 1'b0;
    if (hist.size() >= 3) hist.pop_front();
    p = 0;
    if (m_lock) begin
      if (!s) m_lock = 0;
    end else if (!m_act) begin
      if (s && e) begin
        m_act = 1; m_first = 1; m_since = 0; p = 1;
      end else if (s) m_lock = 1;
    end else if (!s) begin
      m_act = 0;
    end else if (!e) begin
      m_act = 0; m_lock = 1;
    end else if (t) begin
      m_since++;
      need = m_first ? D : (ACC && m_nrep >= A) ? F : R;
      if (m_since == need) begin
        p = 1; m_since = 0;
        if (!m_first && m_nrep < A) m_nrep++;
        m_first = 0;
      end
    end
    if (!m_act) m_nrep = 0;
    exp_o = {p, m_act, ACC && m_act && m_nrep >= A};
  endtask

  task automatic step(input bit t, input bit e, input bit b);
    @(negedge clk);
    u_bus.tick_en = t; u_bus.enable = e; u_bus.btn_level = b;
    @(posedge clk);
    if (reset) m_reset();
    else m_update(t, e, b);
    edge_n++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1);
      total++;
      if (obs !== 3'b000) begin
        bad++;
        $display("FAIL reset_hold got=%b exp=000", obs);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    u_bus.btn_level = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL reset_idle got=%b exp=%b", obs, exp_o);
      end
    end
  endtask

  task automatic test_short_press();
    int np, first_i, fall_i;
    np = 0; first_i = -1; fall_i = -1;
    for (int i = 0; i < 16; i++) begin
      step((i % 3) == 2, 1'b1, i < 6);
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL short_cyc i=%0d got=%b exp=%b", i, obs, exp_o);
      end
      if (obs[2]) begin
        np++;
        if (first_i < 0) first_i = i;
      end
      if (i >= 6 && !obs[1] && fall_i < 0) fall_i = i;
    end
    total++;
    if (np !== 1) begin
      bad++;
      $display("FAIL short_count got=%0d exp=1", np);
    end
    total++;
    if (first_i !== 2) begin
      bad++;
      $display("FAIL short_lat got=%0d exp=2", first_i);
    end
    total++;
    if (fall_i !== 8) begin
      bad++;
      $display("FAIL short_held got=%0d exp=8", fall_i);
    end
  endtask

  task automatic test_long_hold();
    int np, mp;
    np = 0; mp = 0;
    for (int i = 0; i < 40; i++) begin
      step((i % 3) == 2, 1'b1, i < 30);
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL long_cyc i=%0d got=%b exp=%b", i, obs, exp_o);
      end
      if (obs[2]) np++;
      if (exp_o[2]) mp++;
    end
    total++;
    if (np !== mp || np < 3) begin
      bad++;
      $display("FAIL long_count got=%0d exp=%0d", np, mp);
    end
  endtask

  task automatic test_release_coincident();
    int np;
    bit t;
    np = 0;
    for (int i = 0; i < 14; i++) begin
      t = (i == 4) || (i == 6) || (i == 8);
      step(t, 1'b1, i < 6);
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL coinc_cyc i=%0d got=%b exp=%b", i, obs, exp_o);
      end
      if (obs[2]) np++;
    end
    total++;
    if (np !== 1 || obs[1] !== 1'b0) begin
      bad++;
      $display("FAIL coinc got=%0d/%b exp=1/0", np, obs[1]);
    end
  endtask

  task automatic test_enable_drop();
    int np, n, i;
    np = 0; i = 0;
    while (np < 3 && i < 80) begin
      step((i % 3) == 2, 1'b1, 1'b1);
      if (obs[2]) np++;
      i++;
    end
    total++;
    if (np < 3) begin
      bad++;
      $display("FAIL drop_timeout got=%0d exp=3", np);
    end
    n = 0;
    for (int k = 0; k < 30; k++) begin
      step((k % 3) == 2, k >= 6, k < 22);
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL drop_cyc k=%0d got=%b exp=%b", k, obs, exp_o);
      end
      if (obs[2]) n++;
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL drop_locked got=%0d exp=0", n);
    end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, k < 4);
      if (obs[2]) n++;
    end
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL drop_repress got=%0d exp=1", n);
    end
  endtask

  task automatic test_reset_mid();
    int np, i, n;
    np = 0; i = 0; n = 0;
    while (np < 3 && i < 80) begin
      step((i % 3) == 2, 1'b1, 1'b1);
      if (obs[2]) np++;
      i++;
    end
    #2;
    reset = 1'b1;
    u_bus.btn_level = 1'b0;
    m_reset();
    #1;
    total++;
    if (obs !== 3'b000) begin
      bad++;
      $display("FAIL rst_async got=%b exp=000", obs);
    end
    step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step((k % 3) == 2, 1'b1, 1'b0);
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL rst_after k=%0d got=%b exp=%b", k, obs, exp_o);
      end
      if (obs[2]) n++;
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL rst_nopulse got=%0d exp=0", n);
    end
  endtask

  task automatic test_random();
    bit t, e, b, lt;
    lt = 0; e = 1; b = 0;
    for (int i = 0; i < 600; i++) begin
      t = !lt && ($urandom_range(2) == 0);
      if ($urandom_range(19) == 0) e = ~e;
      if ($urandom_range(7) == 0) b = ~b;
      step(t, e, b);
      lt = t;
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL rand i=%0d got=%b exp=%b", i, obs, exp_o);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
  endtask

`ifdef BTN_ACCEL_EN
  task automatic test_accel();
    int tc, k, want;
    tc = 0; k = 0;
    for (int i = 0; i < 96; i++) begin
      step((i % 3) == 2, 1'b1, i < 93);
      if ((i % 3) == 2 && i > 2) tc++;
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL accel_cyc i=%0d got=%b exp=%b", i, obs, exp_o);
      end
      if (obs[2] && i < 93) begin
        want = (k == 0) ? 0 : (k <= 5) ? 3 + 4 * (k - 1) : 19 + (k - 5);
        total++;
        if (tc !== want) begin
          bad++;
          $display("FAIL accel_tick k=%0d got=%0d exp=%0d", k, tc, want);
        end
        k++;
      end
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0; edge_n = 0;
    u_bus.tick_en = 1'b0;
    u_bus.enable = 1'b1;
    u_bus.btn_level = 1'b0;
    m_reset();
    test_reset();
    test_short_press();
    test_long_hold();
    test_release_coincident();
    test_enable_drop();
    test_reset_mid();
`ifdef BTN_ACCEL_EN
    test_accel();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
